traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter N_DIR, default 2, meaning number of approaches (legal 2..8), served round-robin.
REQ-002 Parameter GREEN_TICKS, default 5, meaning green duration in tick pulses (legal >=1).
REQ-003 Parameter YELLOW_TICKS, default 2, meaning yellow duration in tick pulses (legal >=1).
REQ-004 Parameter ALLRED_TICKS, default 1, meaning all-red clearance in tick pulses (legal >=1).
REQ-005 Parameter SKIP_EMPTY, default 0, meaning 1 = skip approaches with no vehicle demand.
REQ-006 clk  input  1  sole clock, all state changes on posedge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 tick  input  1  single-cycle timebase pulse; timers advance only on cycles with tick=1.
REQ-009 veh_det  input  N_DIR  per-approach demand level, sampled only when SKIP_EMPTY=1.
REQ-010 emerg  input  1  level emergency override; forces all approaches to red.
REQ-011 g, y, r  output  N_DIR each  per-approach green/yellow/red lamps, registered.
REQ-012 phase_dir  output  clog2(N_DIR)  index of the approach currently green/yellow/last served.
REQ-013 emerg_act  output  1  high while in the EMERG state.

Function
REQ-014 States SHALL be GREEN, YELLOW, ALLRED, EMERG; a down-counter SHALL be loaded with the state duration on entry.
REQ-015 On a tick cycle the counter SHALL decrement; a tick with counter==1 SHALL change state on that edge, so each state lasts exactly its parameter in ticks.
REQ-016 Transitions: GREEN->YELLOW, YELLOW->ALLRED, ALLRED->GREEN of the next approach (phase_dir+1 mod N_DIR).
REQ-017 With SKIP_EMPTY=1, the next approach SHALL be the first, in round-robin order after phase_dir, with veh_det set; ties resolved by that order.
REQ-018 With SKIP_EMPTY=1 and no other approach demanding at GREEN expiry, the current green SHALL extend by reloading GREEN_TICKS (no yellow).
REQ-019 emerg=1 during GREEN SHALL move to YELLOW on the next edge (counter reloaded, tick not required); YELLOW SHALL complete normally, then enter EMERG.
REQ-020 emerg=1 during ALLRED or YELLOW SHALL enter EMERG when that state's counter expires.
REQ-021 EMERG SHALL hold all r=1 while emerg=1; on emerg=0, enter ALLRED (ALLRED_TICKS), then the next approach per REQ-016/017.
REQ-022 Lamp invariants: exactly one of g/y/r per approach each cycle; at most one approach non-red; YELLOW always between GREEN and any red of the same approach.
REQ-023 Non-tick cycles SHALL not alter counter or state, except the emerg entry of REQ-019.
REQ-024 Counter width SHALL be clog2(max(GREEN_TICKS,YELLOW_TICKS,ALLRED_TICKS)+1).

Reset
REQ-025 rst_n=0 at a posedge SHALL force state GREEN, phase_dir=0, counter=GREEN_TICKS, g[0]=1, r[others]=1, y=0, emerg_act=0, overriding tick and emerg.
REQ-026 Reset asserted mid-phase (any state) SHALL take effect on the next edge with no yellow sequencing.

Structure
REQ-027 Shared package traffic_pkg SHALL hold the state enum and default duration constants.
REQ-028 One sub-module phase_timer (load, tick-decrement, expire flag) SHALL implement the counter; next-approach selection stays in the top.

Verification
REQ-029 N_DIR=2, defaults, tick every 20 cycles: after reset g[0] 5 ticks, y[0] 2 ticks, all red 1 tick, then g[1] 5 ticks, phase_dir=1.
REQ-030 Continuous assertion over 1200 cycles: REQ-022 invariants never violated.
REQ-031 N_DIR=4, SKIP_EMPTY=1, veh_det=4'b0100: after dir0 yellow/all-red, g[2]=1; veh_det=0 during g[2] -> g[2] extends, no yellow.
REQ-032 emerg=1 at tick 2 of g[0]: y[0] next edge for 2 ticks, then emerg_act=1 all red; emerg=0 -> 1 tick all red -> g[1].
REQ-033 rst_n=0 one cycle during y[1]: next edge g[0]=1, phase_dir=0, full 5-tick green follows.
REQ-034 emerg and tick asserted same cycle during ALLRED with counter==1: enters EMERG, no approach turns green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the traffic light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_EMERG  = 2'd3
  } state_t;

  localparam int DEF_GREEN_TICKS  = 5;
  localparam int DEF_YELLOW_TICKS = 2;
  localparam int DEF_ALLRED_TICKS = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration down-counter: load has priority, decrements on tick, saturates at zero.
// expire flags the tick that consumes the last remaining count.
module phase_timer #(
  parameter int W       = 3,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light sequencer with optional demand skipping and emergency all-red.
//   state     | meaning
//   ST_GREEN  | approach phase_dir green, all others red
//   ST_YELLOW | approach phase_dir yellow, all others red
//   ST_ALLRED | clearance interval, every approach red
//   ST_EMERG  | emergency hold, every approach red while emerg is high
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR        = 2,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int SKIP_EMPTY   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic [N_DIR-1:0]           veh_det,
  input  logic                       emerg,
  output logic [N_DIR-1:0]           g,
  output logic [N_DIR-1:0]           y,
  output logic [N_DIR-1:0]           r,
  output logic [$clog2(N_DIR)-1:0]   phase_dir,
  output logic                       emerg_act
);

  localparam int DW   = $clog2(N_DIR);
  localparam int MAXT = max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
  localparam int CW   = $clog2(MAXT + 1);

  state_t          state, nxt_state;
  logic [DW-1:0]   nxt_dir, rr_dir, sel_dir, nxt_app, idx;
  logic            sel_found, other_dem;
  logic            load, expire, emerg_pend;
  logic [CW-1:0]   load_val, count;
  logic [N_DIR-1:0] g_n, y_n;

  phase_timer #(
    .W       (CW),
    .RST_VAL (GREEN_TICKS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .count    (count),
    .expire   (expire)
  );

  // Search order starts just after the current approach and ends on it, so the
  // current approach is only re-selected when it is the sole one demanding.
  always_comb begin
    rr_dir    = DW'((int'(phase_dir) + 1) % N_DIR);
    sel_dir   = rr_dir;
    sel_found = 1'b0;
    other_dem = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = DW'((int'(phase_dir) + k) % N_DIR);
      if (veh_det[idx] && !sel_found) begin
        sel_found = 1'b1;
        sel_dir   = idx;
      end
      if (veh_det[idx] && (k < N_DIR)) other_dem = 1'b1;
    end
    nxt_app = (SKIP_EMPTY != 0) ? sel_dir : rr_dir;
  end

  always_comb begin
    nxt_state = state;
    nxt_dir   = phase_dir;
    load      = 1'b0;
    load_val  = CW'(GREEN_TICKS);
    case (state)
      ST_GREEN: begin
        if (emerg) begin
          nxt_state = ST_YELLOW;
          load      = 1'b1;
          load_val  = CW'(YELLOW_TICKS);
        end else if (expire) begin
          load = 1'b1;
          if ((SKIP_EMPTY != 0) && !other_dem) begin
            load_val = CW'(GREEN_TICKS);
          end else begin
            nxt_state = ST_YELLOW;
            load_val  = CW'(YELLOW_TICKS);
          end
        end
      end
      ST_YELLOW: begin
        if (expire) begin
          if (emerg || emerg_pend) begin
            nxt_state = ST_EMERG;
          end else begin
            nxt_state = ST_ALLRED;
            load      = 1'b1;
            load_val  = CW'(ALLRED_TICKS);
          end
        end
      end
      ST_ALLRED: begin
        if (expire) begin
          if (emerg || emerg_pend) begin
            nxt_state = ST_EMERG;
          end else begin
            nxt_state = ST_GREEN;
            nxt_dir   = nxt_app;
            load      = 1'b1;
            load_val  = CW'(GREEN_TICKS);
          end
        end
      end
      ST_EMERG: begin
        if (!emerg) begin
          nxt_state = ST_ALLRED;
          load      = 1'b1;
          load_val  = CW'(ALLRED_TICKS);
        end
      end
      default: begin
        nxt_state = ST_GREEN;
        load      = 1'b1;
      end
    endcase
  end

  always_comb begin
    g_n = '0;
    y_n = '0;
    if (nxt_state == ST_GREEN)  g_n = N_DIR'(1) << nxt_dir;
    if (nxt_state == ST_YELLOW) y_n = N_DIR'(1) << nxt_dir;
  end

  // A short emerg pulse is remembered so the pending yellow/all-red still ends in EMERG.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_GREEN;
      phase_dir  <= '0;
      emerg_pend <= 1'b0;
      g          <= N_DIR'(1);
      y          <= '0;
      r          <= ~N_DIR'(1);
      emerg_act  <= 1'b0;
    end else begin
      state      <= nxt_state;
      phase_dir  <= nxt_dir;
      emerg_pend <= (nxt_state == ST_EMERG) ? 1'b0 : (emerg_pend | emerg);
      g          <= g_n;
      y          <= y_n;
      r          <= ~(g_n | y_n);
      emerg_act  <= (nxt_state == ST_EMERG);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a 2-approach default instance and a
// 4-approach demand-skipping instance, checked through an expectation queue.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       tick, rst_n_a, rst_n_b, emerg_a, emerg_b;
  logic [1:0] veh_a;
  logic [3:0] veh_b;
  logic [1:0] g_a, y_a, r_a;
  logic [0:0] dir_a;
  logic       ea_a;
  logic [3:0] g_b, y_b, r_b;
  logic [1:0] dir_b;
  logic       ea_b;

  int n_assert = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [1:0] prev_g_a = '0;
  logic [3:0] prev_g_b = '0;
  logic       prev_rst_a = 1'b0;
  logic       prev_rst_b = 1'b0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.N_DIR(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .tick(tick), .veh_det(veh_a), .emerg(emerg_a),
    .g(g_a), .y(y_a), .r(r_a), .phase_dir(dir_a), .emerg_act(ea_a)
  );

  traffic_light_ctrl #(.N_DIR(4), .SKIP_EMPTY(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .tick(tick), .veh_det(veh_b), .emerg(emerg_b),
    .g(g_b), .y(y_b), .r(r_b), .phase_dir(dir_b), .emerg_act(ea_b)
  );

  function automatic logic [31:0] pk_a(input logic [1:0] gg, input logic [1:0] yy,
                                       input logic [1:0] rr, input logic d, input logic e);
    return {24'b0, e, d, rr, yy, gg};
  endfunction

  function automatic logic [31:0] pk_b(input logic [3:0] gg, input logic [3:0] yy,
                                       input logic [3:0] rr, input logic [1:0] d, input logic e);
    return {17'b0, e, d, rr, yy, gg};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required nothing pending", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_a();
    chk(pk_a(g_a, y_a, r_a, dir_a[0], ea_a));
  endtask

  task automatic chk_b();
    chk(pk_b(g_b, y_b, r_b, dir_b, ea_b));
  endtask

  // One clock cycle with the given tick level; returns 1 time unit after the edge.
  task automatic step(input logic t);
    @(negedge clk) tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    repeat (19) step(1'b0);
    step(1'b1);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      bit ok_a, ok_b;
      ok_a = 1'b1;
      ok_b = 1'b1;
      for (int i = 0; i < 2; i++)
        if ($countones({g_a[i], y_a[i], r_a[i]}) != 1) ok_a = 1'b0;
      if ($countones(g_a | y_a) > 1) ok_a = 1'b0;
      if (prev_rst_a && |(prev_g_a & r_a)) ok_a = 1'b0;
      for (int i = 0; i < 4; i++)
        if ($countones({g_b[i], y_b[i], r_b[i]}) != 1) ok_b = 1'b0;
      if ($countones(g_b | y_b) > 1) ok_b = 1'b0;
      if (prev_rst_b && |(prev_g_b & r_b)) ok_b = 1'b0;
      n_assert++;
      assert (ok_a) else begin
        n_fail++;
        $error("FAIL lamp_invariant_a: observed g=%b y=%b r=%b prev_g=%b expected legal lamps",
               g_a, y_a, r_a, prev_g_a);
      end
      n_assert++;
      assert (ok_b) else begin
        n_fail++;
        $error("FAIL lamp_invariant_b: observed g=%b y=%b r=%b prev_g=%b expected legal lamps",
               g_b, y_b, r_b, prev_g_b);
      end
    end
    prev_g_a   = g_a;
    prev_g_b   = g_b;
    prev_rst_a = rst_n_a;
    prev_rst_b = rst_n_b;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick    = 1'b0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    emerg_a = 1'b0;
    emerg_b = 1'b0;
    veh_a   = '0;
    veh_b   = '0;
    step(1'b0);
    step(1'b0);
    push("reset_a", pk_a(2'b01, 2'b00, 2'b10, 1'b0, 1'b0));
    chk_a();
    push("reset_b", pk_b(4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0));
    chk_b();
    armed   = 1'b1;
    rst_n_a = 1'b1;

    // Basic round-robin cycle on the 2-approach instance.
    repeat (4) tick_step();
    push("a_green0_4ticks", pk_a(2'b01, 2'b00, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_yellow0", pk_a(2'b00, 2'b01, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_yellow0_hold", pk_a(2'b00, 2'b01, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_allred", pk_a(2'b00, 2'b00, 2'b11, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_green1", pk_a(2'b10, 2'b00, 2'b01, 1'b1, 1'b0)); chk_a();
    repeat (4) tick_step();
    push("a_green1_4ticks", pk_a(2'b10, 2'b00, 2'b01, 1'b1, 1'b0)); chk_a();
    tick_step();
    push("a_yellow1", pk_a(2'b00, 2'b10, 2'b01, 1'b1, 1'b0)); chk_a();

    // One-cycle reset during yellow of approach 1.
    rst_n_a = 1'b0;
    step(1'b0);
    rst_n_a = 1'b1;
    push("a_reset_mid_yellow", pk_a(2'b01, 2'b00, 2'b10, 1'b0, 1'b0)); chk_a();
    repeat (4) tick_step();
    push("a_green0_after_reset", pk_a(2'b01, 2'b00, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_yellow0_after_reset", pk_a(2'b00, 2'b01, 2'b10, 1'b0, 1'b0)); chk_a();

    // Emergency raised at tick 2 of green 0.
    rst_n_a = 1'b0;
    step(1'b0);
    rst_n_a = 1'b1;
    repeat (2) tick_step();
    emerg_a = 1'b1;
    step(1'b0);
    push("a_emerg_to_yellow", pk_a(2'b00, 2'b01, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_emerg_yellow_hold", pk_a(2'b00, 2'b01, 2'b10, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_emerg_active", pk_a(2'b00, 2'b00, 2'b11, 1'b0, 1'b1)); chk_a();
    repeat (3) tick_step();
    push("a_emerg_hold", pk_a(2'b00, 2'b00, 2'b11, 1'b0, 1'b1)); chk_a();
    emerg_a = 1'b0;
    step(1'b0);
    push("a_emerg_exit_allred", pk_a(2'b00, 2'b00, 2'b11, 1'b0, 1'b0)); chk_a();
    tick_step();
    push("a_green1_after_emerg", pk_a(2'b10, 2'b00, 2'b01, 1'b1, 1'b0)); chk_a();

    // Emergency and tick together on the last all-red tick.
    repeat (7) tick_step();
    push("a_allred_last", pk_a(2'b00, 2'b00, 2'b11, 1'b1, 1'b0)); chk_a();
    repeat (19) step(1'b0);
    emerg_a = 1'b1;
    step(1'b1);
    push("a_emerg_at_allred_expiry", pk_a(2'b00, 2'b00, 2'b11, 1'b1, 1'b1)); chk_a();
    repeat (2) tick_step();
    push("a_no_green_in_emerg", pk_a(2'b00, 2'b00, 2'b11, 1'b1, 1'b1)); chk_a();
    emerg_a = 1'b0;
    step(1'b0);
    tick_step();
    push("a_green0_wrap", pk_a(2'b01, 2'b00, 2'b10, 1'b0, 1'b0)); chk_a();

    // Demand-skipping on the 4-approach instance.
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    veh_b   = 4'b0100;
    step(1'b0);
    rst_n_b = 1'b1;
    repeat (5) tick_step();
    push("b_yellow0", pk_b(4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0)); chk_b();
    repeat (2) tick_step();
    push("b_allred0", pk_b(4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0)); chk_b();
    tick_step();
    push("b_green2_skip", pk_b(4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0)); chk_b();
    veh_b = 4'b0000;
    repeat (5) tick_step();
    push("b_green2_extend", pk_b(4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0)); chk_b();
    repeat (5) tick_step();
    push("b_green2_extend2", pk_b(4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0)); chk_b();
    veh_b = 4'b1001;
    repeat (5) tick_step();
    push("b_yellow2", pk_b(4'b0000, 4'b0100, 4'b1011, 2'd2, 1'b0)); chk_b();
    repeat (2) tick_step();
    push("b_allred2", pk_b(4'b0000, 4'b0000, 4'b1111, 2'd2, 1'b0)); chk_b();
    tick_step();
    push("b_green3_tie_order", pk_b(4'b1000, 4'b0000, 4'b0111, 2'd3, 1'b0)); chk_b();
    veh_b = 4'b0011;
    repeat (5) tick_step();
    push("b_yellow3", pk_b(4'b0000, 4'b1000, 4'b0111, 2'd3, 1'b0)); chk_b();
    repeat (3) tick_step();
    push("b_green0_wrap", pk_b(4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0)); chk_b();

    step(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
